// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Produces the I-memory fetch address with a valid/ready handshake, group
// realignment for multi-instruction fetch, trap/mispredict redirects,
// halt/resume control and a registered redirect pulse for front-end flush.
// Optional build macro: PC_GEN_ALIGN_CHECK_EN adds misaligned-target
// detection (misalign / misalign_addr ports). Without it, target bits [1:0]
// are cleared.
//
// Handshake: pc_valid is high only in RUN. A request is accepted (fire) when
// pc_valid & pc_ready & ~stall; pc never changes while pc_valid=1 and fire=0,
// except when a trap or mispredict redirect overrides it.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0004,
    parameter int              FETCH_WIDTH  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trap,
    input  logic                   miss_pred,
    input  logic [XLEN-1:0]        new_pc,
    input  logic                   br_pred,
    input  logic [XLEN-1:0]        new_pc_pred,
    input  logic                   stall,
    input  logic                   halt_req,
    input  logic                   resume,
    input  logic                   pc_ready,
    output logic [XLEN-1:0]        pc,
    output logic                   pc_valid,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   redirect,
    output logic                   halted,
    output logic [1:0]             state_dbg
`ifdef PC_GEN_ALIGN_CHECK_EN
    ,
    output logic                   misalign,
    output logic [XLEN-1:0]        misalign_addr
`endif
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Byte size of one fetch group and the mask that clears the in-group offset.
    localparam logic [XLEN-1:0] STEP       = XLEN'(4 * FETCH_WIDTH);
    localparam logic [XLEN-1:0] GROUP_MASK = ~(STEP - XLEN'(1));

    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      state_q, state_d;
    logic            redirect_q, redirect_d;
    logic            fire;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] new_pc_al;
    logic [XLEN-1:0] pred_pc_al;

`ifdef PC_GEN_ALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
`else
    // Low target bits are deliberately dropped when alignment checking is off.
    logic unused_target_bits;
    assign unused_target_bits = ^{new_pc[1:0], new_pc_pred[1:0]};
`endif

    assign pc_valid   = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign fire       = pc_valid & pc_ready & ~stall;
    assign pc         = pc_q;
    assign redirect   = redirect_q;
    assign state_dbg  = state_q;
    // Sequential step always lands on the next group boundary; wraps modulo 2^XLEN.
    assign seq_pc     = (pc_q & GROUP_MASK) + STEP;
    assign new_pc_al  = {new_pc[XLEN-1:2], 2'b00};
    assign pred_pc_al = {new_pc_pred[XLEN-1:2], 2'b00};

    // Slot mask: slots before the in-group word offset of pc are not valid.
    generate
        if (FETCH_WIDTH == 1) begin : g_single
            assign fetch_mask = 1'b1;
        end else begin : g_group
            localparam int OFFW = $clog2(FETCH_WIDTH);
            logic [OFFW-1:0] slot_off;
            assign slot_off = pc_q[OFFW+1:2];
            for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
                assign fetch_mask[i] = (OFFW'(i) >= slot_off);
            end
        end
    endgenerate

    // Next-state / next-PC selection in priority order: trap, mispredict,
    // halt request, hold without fire, predicted branch, sequential step.
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        redirect_d = 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
`endif

        // Control transitions when no misaligned target overrides them.
        // In HALT a redirect takes precedence over resume and keeps HALT.
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: if (resume && !trap && !miss_pred) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (trap) begin
            pc_d       = TRAP_VECTOR;
            redirect_d = 1'b1;
        end else if (miss_pred) begin
`ifdef PC_GEN_ALIGN_CHECK_EN
            if (new_pc[1:0] != 2'b00) begin
                pc_d            = TRAP_VECTOR;
                redirect_d      = 1'b1;
                misalign_d      = 1'b1;
                misalign_addr_d = new_pc;
                state_d         = (state_q == ST_BOOT) ? ST_RUN : state_q;
            end else
`endif
            begin
                pc_d       = new_pc_al;
                redirect_d = 1'b1;
            end
        end else if ((state_q == ST_RUN) && !halt_req && fire) begin
            if (br_pred) begin
`ifdef PC_GEN_ALIGN_CHECK_EN
                if (new_pc_pred[1:0] != 2'b00) begin
                    pc_d            = TRAP_VECTOR;
                    redirect_d      = 1'b1;
                    misalign_d      = 1'b1;
                    misalign_addr_d = new_pc_pred;
                    state_d         = state_q;
                end else
`endif
                begin
                    pc_d = pred_pc_al;
                end
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // PC, FSM state and redirect pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            state_q    <= ST_BOOT;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            redirect_q <= redirect_d;
        end
    end

`ifdef PC_GEN_ALIGN_CHECK_EN
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;

    // Misalign pulse and last offending target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-stage program-counter generator and successor to the single-width PC register. It supports a configurable address width, reset and trap vectors, and multi-instruction fetch groups with a per-slot valid mask. It adds a valid/ready handshake toward instruction memory, trap redirect, halt/resume control and a registered redirect pulse for front-end flush. It sits at the head of the fetch stage and drives the I-memory address and the fetch-buffer slot mask.

Parameters:
XLEN, 32, address width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0004, PC value loaded on trap.
FETCH_WIDTH, 1, instructions per fetch group; legal values 1, 2, 4. STEP = 4*FETCH_WIDTH bytes.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
trap  in  1  redirect to TRAP_VECTOR; highest priority.
miss_pred  in  1  branch mispredict; redirect to new_pc.
new_pc  in  XLEN  resolved target from execute.
br_pred  in  1  predicted-taken branch for the current group.
new_pc_pred  in  XLEN  predicted target.
stall  in  1  pipeline stall; hold the PC.
halt_req  in  1  request the halt state (debug/WFI).
resume  in  1  leave the halt state.
pc_ready  in  1  I-memory accepts the address this cycle.
pc  out  XLEN  current fetch address.
pc_valid  out  1  pc is a valid fetch request.
fetch_mask  out  FETCH_WIDTH  bit i set when slot i of the group is valid.
redirect  out  1  registered pulse: pc was loaded by trap or miss_pred on the previous edge.
halted  out  1  high while in HALT.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: pc=RESET_VECTOR, state=BOOT, pc_valid=0, redirect=0, halted=0. fetch_mask is combinational from pc.
- States are BOOT, RUN and HALT. The state is registered. pc_valid is 1 only in RUN; halted is 1 only in HALT.
- Handshake: fire = pc_valid & pc_ready & ~stall. pc must stay stable while pc_valid=1 and fire=0.
- Next-PC priority is evaluated every edge, highest first:
  1. trap: pc=TRAP_VECTOR, redirect=1.
  2. miss_pred: pc=new_pc, redirect=1.
  3. In RUN with halt_req: state=HALT, pc holds.
  4. In RUN with ~fire: pc holds.
  5. In RUN with fire & br_pred: pc=new_pc_pred.
  6. In RUN with fire: pc=(pc & ~(STEP-1)) + STEP, i.e. the next aligned group.
- Redirects (trap, miss_pred) are honoured in every state and regardless of stall or pc_ready.
  - In BOOT, a redirect also moves the state to RUN.
  - In HALT, a redirect updates pc and the state stays HALT.
- BOOT moves to RUN unconditionally on the first edge after reset release.
- HALT moves to RUN on resume. While in HALT, halt_req is ignored.
- In RUN, a simultaneous trap/miss_pred and halt_req loads the redirect target and enters HALT in the same edge.
- redirect is 0 on any edge without trap or miss_pred.
- Targets: bits [1:0] of new_pc and new_pc_pred are forced to 0 (see Optional Feature for the alternative).
- Arithmetic is modulo 2^XLEN; a sequential step past the top wraps to 0.
- fetch_mask: off = pc[log2(STEP)-1:2]; bit i = (i >= off). With FETCH_WIDTH=1, fetch_mask is constantly 1. This lets a redirect into mid-group fetch only the remaining slots; the next sequential fetch realigns to the group boundary.
- Reset asserted mid-operation immediately forces the reset values, independent of clk.

Optional Feature:
Macro PC_GEN_ALIGN_CHECK_EN.
- When defined, two extra ports are added:
  - misalign  out  1: registered one-cycle pulse.
  - misalign_addr  out  XLEN: holds the last offending target; reset 0.
- A miss_pred or a firing br_pred whose target has [1:0]!=0 loads pc=TRAP_VECTOR, asserts redirect=1 and misalign=1, and captures the raw target in misalign_addr. The state is unchanged except BOOT, which moves to RUN.
- When not defined, these ports are absent and target bits [1:0] are silently cleared.

Test Plan:
1. Reset/boot: release reset_n with RESET_VECTOR=0x100, pc_ready=1 -> pc_valid=0 for one cycle, then pc=0x100, 0x104, 0x108 on successive edges.
2. Group realign: FETCH_WIDTH=4, miss_pred with new_pc=0x2008 -> redirect=1 next cycle, pc=0x2008, fetch_mask=4'b1100; next fire -> pc=0x2010, fetch_mask=4'b1111.
3. Priority: trap, miss_pred(0x40), stall and halt_req all asserted in RUN -> pc=TRAP_VECTOR, state=HALT, halted=1; then resume -> pc_valid=1 at TRAP_VECTOR.
4. Backpressure: pc=0x200, br_pred=1 to 0x800, pc_ready=0 for 3 cycles -> pc holds 0x200; pc_ready=1 -> pc=0x800.
5. Wrap: XLEN=32, pc=0xFFFF_FFFC, fire -> pc=0x0000_0000.
6. Align check (PC_GEN_ALIGN_CHECK_EN): miss_pred with new_pc=0x1002 -> pc=TRAP_VECTOR, misalign=1 for one cycle, misalign_addr=0x1002. Without the macro, the same stimulus gives pc=0x1000.
